// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
//   Scan controller for an 8-digit common-anode seven-segment display.
//   A 32-bit value arrives over a valid/ready handshake. It is held in a one-entry
//   pending buffer until the next frame boundary, then it becomes the displayed value.
//   Swapping only at the boundary keeps every frame consistent: a frame never mixes
//   old and new digits. One digit is driven at a time, and each digit is held for
//   CLK_DIV clock cycles.
//
// Ports
//   clk           system clock, rising edge
//   reset         synchronous reset, active low
//   i_data        value to display; nibble i drives digit i
//   i_valid       i_data is valid
//   o_ready       pending buffer is empty; a transfer happens when i_valid & o_ready
//   i_blank_mask  bit i = 1 blanks digit i; sampled live, not buffered
//   o_seg         segments, active low, {dp,g,f,e,d,c,b,a}; dp is never lit
//   o_sel         digit select, active-low one-hot
//   o_frame_done  one-cycle pulse when digit 7 finishes its slot
module seg7_scan_ctrl #(
    parameter int CLK_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_data,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [7:0]  i_blank_mask,
    output logic [7:0]  o_seg,
    output logic [7:0]  o_sel,
    output logic        o_frame_done
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] div_cnt;
    logic [2:0]    dig_idx;
    logic [31:0]   disp_reg;
    logic [31:0]   pending;
    logic          pending_full;
    logic          pending_full_nxt;
    logic          slot_end;
    logic          frame_end;
    logic          accept;
    logic [3:0]    nibble;
    logic [7:0]    hex_code;

    assign slot_end  = (div_cnt == CW'(CLK_DIV - 1));
    assign frame_end = slot_end && (dig_idx == 3'd7);
    assign accept    = i_valid && o_ready;
    assign nibble    = disp_reg[{dig_idx, 2'b00} +: 4];

    // The transfer takes priority over capture. A capture can only happen while the
    // buffer is empty, and then there is nothing to transfer. So a value captured on
    // a boundary waits one full frame; it is never bypassed into disp_reg.
    always_comb begin
        pending_full_nxt = pending_full;
        if (frame_end && pending_full)
            pending_full_nxt = 1'b0;
        else if (accept)
            pending_full_nxt = 1'b1;
    end

    always_comb begin
        hex_code = 8'hFF;
        case (nibble)
            4'h0: hex_code = 8'hC0;
            4'h1: hex_code = 8'hF9;
            4'h2: hex_code = 8'hA4;
            4'h3: hex_code = 8'hB0;
            4'h4: hex_code = 8'h99;
            4'h5: hex_code = 8'h92;
            4'h6: hex_code = 8'h82;
            4'h7: hex_code = 8'hF8;
            4'h8: hex_code = 8'h80;
            4'h9: hex_code = 8'h90;
            4'hA: hex_code = 8'h88;
            4'hB: hex_code = 8'h83;
            4'hC: hex_code = 8'hC6;
            4'hD: hex_code = 8'hA1;
            4'hE: hex_code = 8'h86;
            4'hF: hex_code = 8'h8E;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt      <= '0;
            dig_idx      <= 3'd0;
            disp_reg     <= 32'h0;
            pending      <= 32'h0;
            pending_full <= 1'b0;
            o_ready      <= 1'b0;
            o_frame_done <= 1'b0;
            o_sel        <= 8'hFF;
            o_seg        <= 8'hFF;
        end else begin
            div_cnt <= slot_end ? '0 : div_cnt + CW'(1);
            // dig_idx is 3 bits wide, so it wraps from 7 to 0 by itself.
            if (slot_end)
                dig_idx <= dig_idx + 3'd1;

            if (frame_end && pending_full)
                disp_reg <= pending;
            if (accept)
                pending <= i_data;
            pending_full <= pending_full_nxt;
            o_ready      <= ~pending_full_nxt;
            o_frame_done <= frame_end;

            // The outputs follow the current dig_idx, so they lag it by one cycle.
            o_sel <= ~(8'b1 << dig_idx);
            o_seg <= i_blank_mask[dig_idx] ? 8'hFF : hex_code;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Testbench for seg7_scan_ctrl with CLK_DIV = 4.
// The driver works on the falling edge. For each rising edge it predicts the outputs
// from a cycle-count model and pushes that prediction into a queue. The monitor pops
// one entry after each rising edge and compares every output against it.
module tb_seg7_scan_ctrl;

    localparam int CLK_DIV = 4;
    localparam int FRAME   = 8 * CLK_DIV;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] i_data = 32'h0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [7:0]  i_blank_mask = 8'h00;
    logic [7:0]  o_seg;
    logic [7:0]  o_sel;
    logic        o_frame_done;

    seg7_scan_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_blank_mask (i_blank_mask),
        .o_seg        (o_seg),
        .o_sel        (o_sel),
        .o_frame_done (o_frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] seg;
        logic [7:0] sel;
        logic       rdy;
        logic       fd;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    logic [7:0] hex_lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reference model: k counts the rising edges since reset was released. The
    // display value changes only on the last edge of each frame.
    int          k;
    bit          m_full;
    bit          m_rdy;
    logic [31:0] m_pend;
    logic [31:0] m_disp;
    bit          last_fd;

    task automatic step(input bit rst, input bit vld, input logic [31:0] d,
                        input logic [7:0] bl);
        exp_t e;
        int   dg;
        bit   bnd;
        @(negedge clk);
        reset = rst; i_valid = vld; i_data = d; i_blank_mask = bl;
        if (!rst) begin
            e = '{seg: 8'hFF, sel: 8'hFF, rdy: 1'b0, fd: 1'b0};
            k = 0; m_full = 0; m_rdy = 0; m_disp = 32'h0; m_pend = 32'h0;
        end else begin
            dg    = (k / CLK_DIV) % 8;
            bnd   = (k % FRAME) == FRAME - 1;
            e.sel = ~(8'h01 << dg);
            e.seg = bl[dg] ? 8'hFF : hex_lut[m_disp[4*dg +: 4]];
            e.fd  = bnd;
            if (bnd && m_full) begin
                m_disp = m_pend; m_full = 0;
            end else if (vld && m_rdy) begin
                m_pend = d; m_full = 1;
            end
            m_rdy = !m_full;
            e.rdy = m_rdy;
            k++;
        end
        last_fd = e.fd;
        q.push_back(e);
    endtask

    task automatic idle(input int n, input logic [7:0] bl);
        for (int i = 0; i < n; i++) step(1, 0, $urandom, bl);
    endtask

    // Hold i_valid until the model reports that the value was accepted.
    task automatic send(input logic [31:0] d, input logic [7:0] bl);
        bit done = 0;
        for (int i = 0; i < 4 * FRAME && !done; i++) begin
            done = m_rdy;
            step(1, 1, d, bl);
        end
        if (!done) begin
            failures++;
            $display("FAIL send_timeout data=%h never accepted", d);
        end
    endtask

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        cyc++;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            cmp("seg",        o_seg,                 e.seg);
            cmp("sel",        o_sel,                 e.sel);
            cmp("ready",      {7'd0, o_ready},       {7'd0, e.rdy});
            cmp("frame_done", {7'd0, o_frame_done},  {7'd0, e.fd});
        end
    end

    initial begin
        bit found;
        // Reset held for 5 cycles; input activity during reset must be ignored.
        for (int i = 0; i < 5; i++) step(0, 1, $urandom, 8'h00);
        idle(3, 8'h00);

        // Single value, then two frames for it to appear and be shown in full.
        send(32'h0123_89AB, 8'h00);
        idle(3 * FRAME, 8'h00);

        // Back-pressure: the second value waits until the first is transferred.
        send(32'hFFFF_FFFF, 8'h00);
        send(32'h0000_0000, 8'h00);
        idle(3 * FRAME, 8'h00);

        // Capture in the cycle where o_frame_done is high.
        found = 0;
        for (int i = 0; i < 3 * FRAME && !found; i++) begin
            if (last_fd && m_rdy) found = 1;
            else step(1, 0, $urandom, 8'h00);
        end
        if (!found) begin
            failures++;
            $display("FAIL boundary_wait no frame_done with empty buffer");
        end
        step(1, 1, 32'hDEAD_BEEF, 8'h00);
        idle(3 * FRAME, 8'h00);

        // Blanking of the low digits, then a reset mid-frame with the buffer full.
        idle(FRAME, 8'h0F);
        send(32'h7654_3210, 8'h0F);
        idle(5, 8'h0F);
        step(0, 0, 32'h0, 8'h00);
        idle(2 * FRAME, 8'h00);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            bit          r  = ($urandom_range(0, 199) != 0);
            bit          v  = ($urandom_range(0, 3) == 0);
            logic [7:0]  bl = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            step(r, v, $urandom, bl);
        end
        idle(2 * FRAME, 8'h00);

        @(posedge clk); @(posedge clk); #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
